// File: rtl/uart_tx_buffered_if.sv
// Write-side and serial-side signals of the buffered UART transmitter.
//   master: drives wr_en/wr_data, observes status and the serial line.
//   slave : the transmitter itself.
//   wr_en, wr_data       byte push request (pushed when wr_en=1 and full=0)
//   full, empty          FIFO occupancy flags
//   overflow             one-cycle pulse when a write hits a full FIFO
//   busy, tx_done_tick   frame in progress / one-cycle end-of-stop pulse
//   tx                   serial line, idle high
interface uart_tx_buffered_if #(
  parameter int DBITS = 8
);
  logic             wr_en;
  logic [DBITS-1:0] wr_data;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             busy;
  logic             tx_done_tick;
  logic             tx;

  modport master (
    output wr_en, wr_data,
    input  full, empty, overflow, busy, tx_done_tick, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, overflow, busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a small write FIFO. Serializes LSB first,
// timed by a 16x oversampling tick from an external baud generator.
//   clk_50MHz  system clock, rising edge
//   reset_n    asynchronous active-low reset; discards queued bytes
//   tick       one-cycle oversampling strobe, 16 per bit
//   bus        uart_tx_buffered_if.slave (write port, flags, serial line)
module uart_tx_buffered #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              tick,
  uart_tx_buffered_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int NW    = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [3:0]       S_LAST  = 4'd15;
  localparam logic [3:0]       SB_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]    N_LAST  = NW'(DBITS - 1);
  localparam logic [FIFO_AW:0] CNT_MAX = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBITS-1:0]  b_q, b_d;
  logic              tx_q, tx_d;

  logic [DBITS-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]  cnt_q;

  logic push, pop, full, empty, done;

  // full is the pre-pop view, so a write in the cycle of a pop from a
  // full FIFO is still refused.
  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);
  assign push  = bus.wr_en & ~full;

  // ---------------- FIFO ----------------
  always_ff @(posedge clk_50MHz) begin
    if (push) mem_q[wptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          b_d     = mem_q[rptr_q];
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the same
    // edge as the state and stays glitch-free behind tx_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.overflow     = bus.wr_en & full;
  assign bus.busy         = (state_q != IDLE);
  assign bus.tx_done_tick = done;
  assign bus.tx           = tx_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: stimulus pushes expected bytes into a queue,
// a tick-driven serial receiver pops and compares each decoded frame.
module tb_uart_tx_buffered;
  logic clk_50MHz = 1'b0;
  logic reset_n   = 1'b0;
  logic tick      = 1'b0;

  uart_tx_buffered_if #(.DBITS(8)) bus();

  uart_tx_buffered #(.DBITS(8), .SB_TICK(16), .FIFO_AW(2)) u_dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .tick      (tick),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int errors = 0, checks = 0, cyc = 0, tick_m = 4;
  int done_cnt = 0, ovf_cnt = 0, starts = 0, bfall = 0;
  int chg_q[$];
  int gap_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic at_pos(); @(posedge clk_50MHz); #1; endtask
  task automatic at_neg(); @(negedge clk_50MHz); #1; endtask

  // Called at posedge+1; byte is sampled on the next edge.
  task automatic wr1(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    at_pos();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, input string nm);
    int k = 0;
    while (done_cnt < target && k < bound) begin at_neg(); k++; end
    chk(nm, done_cnt, target);
  endtask

  task automatic wait_starts(input int target, input int bound, input string nm);
    int k = 0;
    while (starts < target && k < bound) begin at_neg(); k++; end
    chk(nm, starts, target);
  endtask

  // Line timing of one frame from recorded tx change cycles; the anchor is
  // the end of the start bit, so d[0] must be 1.
  task automatic frame_check(input logic [7:0] d, input int bitc, input int ws);
    logic [9:0] line;
    int ex[$];
    int c0, c1, m;
    m    = bitc / 16;
    line = {1'b1, d, 1'b0};
    for (int j = 1; j <= 9; j++)
      if (line[j] != line[j-1]) ex.push_back((j - 1) * bitc);
    chk("line_changes", chg_q.size(), ex.size() + 1);
    if (chg_q.size() == ex.size() + 1) begin
      c0 = chg_q[0];
      c1 = chg_q[1];
      chk("tx_fall_latency", c0 - ws, 1);
      chk_rng("start_bit_len", c1 - c0, bitc - m + 1, bitc);
      for (int k = 1; k < ex.size(); k++)
        chk("bit_edge_offset", chg_q[k+1] - c1, ex[k]);
      chk("stop_end", bfall - c1, 9 * bitc);
      chk_rng("frame_len", bfall - c0, 10 * bitc - m + 1, 10 * bitc);
    end
  endtask

  // Baud tick model: one pulse every tick_m clocks.
  initial begin : tick_gen
    int tc;
    tc = 0;
    forever begin
      at_pos();
      tc   = (tc >= tick_m - 1) ? 0 : tc + 1;
      tick = (tc == tick_m - 1);
    end
  end

  initial forever begin @(posedge clk_50MHz); cyc++; end

  // Line/status event recorder.
  initial begin : mon
    logic last_tx, last_busy;
    int idle;
    last_tx = 1'b1; last_busy = 1'b0; idle = 0;
    forever begin
      @(negedge clk_50MHz);
      if (bus.tx !== last_tx) chg_q.push_back(cyc);
      if (bus.busy && !last_busy) begin starts++; gap_q.push_back(idle); end
      if (!bus.busy && last_busy) bfall = cyc;
      idle = bus.busy ? 0 : idle + 1;
      if (bus.tx_done_tick === 1'b1) done_cnt++;
      if (bus.overflow === 1'b1) ovf_cnt++;
      last_tx = bus.tx; last_busy = bus.busy;
    end
  end

  // 16x oversampling receiver: mid-bit samples at ticks 8+16*i.
  initial begin : rx_mon
    logic on;
    int t;
    logic [7:0] sh, e;
    on = 1'b0; t = 0; sh = '0;
    forever begin
      @(negedge clk_50MHz);
      if (!reset_n) on = 1'b0;
      else begin
        if (!on && bus.tx === 1'b0) begin on = 1'b1; t = 0; sh = '0; end
        if (on && tick) begin
          t++;
          if (t == 8) chk("rx_start_bit", bus.tx, 0);
          else if (t > 8 && t < 152 && ((t - 8) % 16) == 0) sh = {bus.tx, sh[7:1]};
          else if (t == 152) begin
            on = 1'b0;
            chk("rx_stop_bit", bus.tx, 1);
            if (exp_q.size() == 0) chk("rx_unexpected_frame", sh, -1);
            else begin
              e = exp_q.pop_front();
              chk("rx_byte", sh, e);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int ws, d0, o0, s0, s1, k;
    bus.wr_en = 1'b0; bus.wr_data = '0;

    // Reset held while writes toggle: line idle, FIFO empty, no pulses.
    for (int i = 0; i < 8; i++) begin
      at_pos();
      bus.wr_en = ~bus.wr_en; bus.wr_data = 8'(i * 37);
      at_neg();
      chk("reset_outputs", {bus.tx, bus.busy, bus.empty, bus.full,
                            bus.overflow, bus.tx_done_tick}, 6'b101000);
    end
    at_pos();
    bus.wr_en = 1'b0; reset_n = 1'b1;
    repeat (3) at_pos();
    chk("reset_no_pulses", done_cnt + ovf_cnt, 0);

    // Single byte 0x55, tick every 4 clocks.
    chg_q.delete();
    d0 = done_cnt;
    exp_q.push_back(8'h55);
    wr1(8'h55);
    ws = cyc;
    at_neg();
    chk("lat_tx_before", bus.tx, 1);
    chk("lat_busy_before", bus.busy, 0);
    chk("lat_empty_before", bus.empty, 0);
    at_pos(); at_neg();
    chk("lat_tx_after", bus.tx, 0);
    chk("lat_busy_after", bus.busy, 1);
    chk("lat_empty_after", bus.empty, 1);
    wait_done(d0 + 1, 1000, "single_done_pulse");
    at_neg(); at_neg();
    chk("single_done_once", done_cnt, d0 + 1);
    frame_check(8'h55, 64, ws);

    // Queue: lead byte starts a frame, then 4 back-to-back writes fill it.
    at_pos();
    d0 = done_cnt;
    exp_q.push_back(8'h33);
    wr1(8'h33);
    repeat (10) at_pos();
    gap_q.delete();
    s0 = starts;
    exp_q.push_back(8'hA3); exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    wr1(8'hA3); wr1(8'h0F); wr1(8'hFF); wr1(8'h00);
    at_neg();
    chk("queue_full", bus.full, 1);
    chk("queue_not_empty", bus.empty, 0);
    wait_starts(s0 + 3, 3000, "queue_third_start");
    chk("queue_empty_before_last", bus.empty, 0);
    wait_starts(s0 + 4, 1000, "queue_fourth_start");
    chk("queue_empty_after_last", bus.empty, 1);
    wait_done(d0 + 5, 4000, "queue_done_count");
    at_neg(); at_neg();
    chk("queue_gap_count", gap_q.size(), 4);
    foreach (gap_q[i]) chk("queue_idle_gap", gap_q[i], 1);

    // Overflow: 5 writes while a frame holds the FIFO, 5th dropped.
    at_pos();
    d0 = done_cnt; o0 = ovf_cnt;
    exp_q.push_back(8'h11);
    wr1(8'h11);
    repeat (10) at_pos();
    exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    exp_q.push_back(8'h23); exp_q.push_back(8'h24);
    wr1(8'h21); wr1(8'h22); wr1(8'h23); wr1(8'h24); wr1(8'h25);
    at_neg();
    chk("ovf_full", bus.full, 1);
    chk("ovf_pulse_once", ovf_cnt - o0, 1);
    // Write in the idle cycle whose edge pops: still refused.
    k = 0;
    do begin at_neg(); k++; end while (bus.tx_done_tick !== 1'b1 && k < 1000);
    chk("ovf_lead_done_seen", bus.tx_done_tick, 1);
    at_pos();
    bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    at_neg();
    chk("popcyc_overflow", bus.overflow, 1);
    chk("popcyc_full", bus.full, 1);
    chk("popcyc_busy", bus.busy, 0);
    at_pos();
    bus.wr_en = 1'b0;
    at_neg();
    chk("popcyc_full_after", bus.full, 0);
    chk("popcyc_busy_after", bus.busy, 1);
    chk("ovf_pulse_total", ovf_cnt - o0, 2);
    wait_done(d0 + 5, 4000, "ovf_done_count");
    s0 = starts;
    repeat (100) at_neg();
    chk("ovf_no_extra_frame", starts, s0);
    chk("ovf_queue_drained", exp_q.size(), 0);

    // Mid-frame reset during DATA of 0x81 with two bytes queued.
    at_pos();
    d0 = done_cnt;
    wr1(8'h81); wr1(8'h42); wr1(8'h43);
    repeat (150) at_pos();
    chk("midrst_busy_before", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx", bus.tx, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_full", bus.full, 0);
    repeat (3) at_pos();
    reset_n = 1'b1;
    s1 = starts;
    repeat (800) at_pos();
    chk("midrst_no_frames", starts, s1);
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_tx_idle", bus.tx, 1);

    // Real rate: M=325, byte 0x4B.
    tick_m = 325;
    repeat (2) at_pos();
    chg_q.delete();
    d0 = done_cnt;
    exp_q.push_back(8'h4B);
    wr1(8'h4B);
    ws = cyc;
    wait_done(d0 + 1, 60000, "real_done_pulse");
    at_neg(); at_neg();
    frame_check(8'h4B, 5200, ws);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

UART transmitter for the CNC command/status link, the transmit counterpart of the UART receiver. It consumes the 16x-oversampling `tick` from the baud rate generator (9600 baud at 50 MHz) and serializes bytes onto `tx` as 8N1, LSB first. A small internal FIFO lets the controller queue several bytes without waiting for each frame to finish.

## Interface
- `DBITS`, 8: data bits per frame.
- `SB_TICK`, 16: ticks in the stop bit (16 = 1 stop bit).
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW (4).
- `clk_50MHz`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle sample tick from the baud rate generator, 16 per bit.
- `wr_en`  in  1  write strobe; `wr_data` is pushed when `wr_en=1` and `full=0`.
- `wr_data`  in  DBITS  byte to transmit.
- `full`  out  1  FIFO holds 2^FIFO_AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `overflow`  out  1  one-cycle pulse when `wr_en=1` while `full=1`; the byte is dropped.
- `busy`  out  1  high in any state other than IDLE.
- `tx_done_tick`  out  1  one-cycle pulse at the end of each stop bit.
- `tx`  out  1  serial line, idle high.

## Operation
- FIFO: circular buffer with a write pointer, a read pointer, and a count of width FIFO_AW+1. Pointers wrap modulo the depth.
- Push on `wr_en & ~full`. Pop when the FSM leaves IDLE.
- Simultaneous push and pop: both occur and the count is unchanged.
- `full` is evaluated before the pop in the same cycle. A write while full is dropped even if a pop happens in that cycle, and `overflow` pulses.
- FSM states are IDLE, START, DATA, STOP. Internal registers:
  - tick counter `s` (4 bits)
  - bit counter `n` (3 bits for DBITS=8)
  - shift register `b` (DBITS)
  - output register `tx_reg`
- IDLE:
  - `tx=1`.
  - If `~empty`: pop, load `b` with the FIFO head, clear `s`, go to START.
- START:
  - `tx=0`.
  - On each `tick`, if `s==15`: clear `s` and `n`, go to DATA. Otherwise `s++`.
- DATA:
  - `tx=b[0]`.
  - On each `tick`, if `s==15`: clear `s` and shift `b` right by 1. Then, if `n==DBITS-1`, go to STOP; otherwise `n++`.
  - Otherwise, on `tick`, `s++`.
- STOP:
  - `tx=1`.
  - On each `tick`, if `s==SB_TICK-1`: pulse `tx_done_tick` and go to IDLE. Otherwise `s++`.
- Cycles without `tick` hold all counters.
- `tx` is registered (`tx_reg`), so there are no combinational glitches on the line.
- Back-to-back frames: after STOP→IDLE, a non-empty FIFO causes a pop on the next clock. This gives exactly one clock of extra idle high between frames.
- Asynchronous reset (`reset_n=0`), including mid-frame:
  - State returns to IDLE.
  - `tx=1`, `busy=0`, `tx_done_tick=0`, `overflow=0`.
  - FIFO pointers and count are cleared (`empty=1`, `full=0`); queued data is discarded.
  - `s`, `n`, and `b` are cleared.

## Timing
- Latency: `wr_en` sampled at edge k with the FIFO empty and the FSM idle:
  - The FIFO count becomes 1 at edge k.
  - The pop occurs, the FSM enters START, and `tx` falls at edge k+1.
  - `busy` rises at edge k+1.
- Start bit length depends on tick phase: from 15·M+1 to 16·M clocks (M = generator limit, 325).
- Each data bit is exactly 16·M clocks (5200).
- The stop bit is exactly SB_TICK·M clocks.
- `tx_done_tick` is high for exactly one clock, coincident with the STOP→IDLE transition.
- `busy` falls on that same edge.
- Throughput: one frame per (10·16·M + 1) clocks, within the start-bit phase variation.

## Test plan
- Reset: hold `reset_n=0` with `wr_en` toggling. Required: `tx=1`, `busy=0`, `empty=1`, `full=0`, and no pulses.
- Single byte: use a bench tick every 4 clocks (M=4) and write 0x55. Required:
  - `tx` falls 1 clock after the write.
  - The line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each data bit 64 clocks.
  - One `tx_done_tick` pulse.
- Queue: write 0xA3, 0x0F, 0xFF, 0x00 on 4 consecutive clocks. Required:
  - `full=1` after the 4th write.
  - Four frames decoded by the bench receiver in order, with one idle clock between frames.
  - `empty=1` after the first frame starts plus 3 more pops.
- Overflow: write 5 bytes while FIFO-full with no pop. Required:
  - The 5th write is dropped and `overflow` pulses once.
  - Exactly 4 bytes are transmitted.
  - Also cover a write while full in the cycle of a pop: that write is still dropped.
- Mid-frame reset: assert `reset_n=0` during DATA of 0x81 with 2 bytes queued. Required: `tx=1` immediately, no further frames, and `empty=1`.
- Real rate: instantiate the generator (M=325) and send 0x4B. Required: each data bit is 5200 clocks, and the total frame is between 51676 and 52000 clocks.
